// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage RV32I core.
// It makes the stall, flush and bubble decisions, selects EX operand forwarding and keeps debug counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_serialize,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    state_t      r_state;
    logic        r_ex_v;
    logic        r_mem_v;
    logic        r_wb_v;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic w_any_v;
    logic w_mem_wait;
    logic w_redirect;
    logic w_serialize;
    logic w_load_use;

    assign w_any_v    = r_ex_v | r_mem_v | r_wb_v;
    assign w_mem_wait = dmem_req & ~dmem_ready;
    assign w_redirect = ~w_mem_wait & ex_redirect & r_ex_v;
    assign w_serialize = ~w_mem_wait & ~w_redirect & id_valid & id_serialize & w_any_v;
    assign w_load_use = ~w_mem_wait & ~w_redirect & ~w_serialize & ex_mem_read & r_ex_v &
                        (ex_rd != 5'd0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    // The nearer producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       mem_hit_en,
        input logic [4:0] m_rd,
        input logic       wb_hit_en,
        input logic [4:0] w_rd
    );
        if (mem_hit_en && m_rd != 5'd0 && m_rd == rs)
            return 2'b01;
        else if (wb_hit_en && w_rd != 5'd0 && w_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        if (!rst) begin
            if (w_mem_wait) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (w_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_serialize || w_load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            fwd_a = fwd_sel(ex_rs1, mem_reg_write & r_mem_v, mem_rd, wb_regwrite & r_wb_v, wb_rd);
            fwd_b = fwd_sel(ex_rs2, mem_reg_write & r_mem_v, mem_rd, wb_regwrite & r_wb_v, wb_rd);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= S_RUN;
            r_ex_v      <= 1'b0;
            r_mem_v     <= 1'b0;
            r_wb_v      <= 1'b0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            // A memory wait freezes EX and MEM; WB drains into a bubble.
            if (ex_mem_stall) begin
                r_wb_v <= 1'b0;
            end else begin
                r_ex_v  <= id_valid & ~id_ex_flush;
                r_mem_v <= r_ex_v;
                r_wb_v  <= r_mem_v;
            end

            if (pc_stall && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_redirect && r_flush_cnt != 16'hFFFF)
                r_flush_cnt <= r_flush_cnt + 16'd1;

            case (r_state)
                S_RUN: begin
                    if (w_serialize)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!w_mem_wait && (w_redirect || !w_any_v))
                        r_state <= S_RUN;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign stall_cycles = r_stall_cnt;
    assign flush_count  = r_flush_cnt;

endmodule
